// File: rtl/niederreiter_pkg.sv
// ----------------------------------------------------------------------------
// niederreiter_pkg
//
// Shared constants and types for the Niederreiter host sequencer.
//   MSG_BYTES  : plaintext bytes written into the encryptor per frame
//   CT_BITS    : ciphertext width produced by the encryptor
//   OUT_BYTES  : ciphertext bytes returned to the host, ceil(CT_BITS/8)
//   PAD_BITS   : ciphertext width rounded up to whole bytes
//   state_e    : sequencer FSM states
// ----------------------------------------------------------------------------
package niederreiter_pkg;

    localparam int MSG_BYTES  = 40;
    localparam int CT_BITS    = 297;
    localparam int OUT_BYTES  = (CT_BITS + 7) / 8;
    localparam int PAD_BITS   = OUT_BYTES * 8;
    localparam int PAD_ZEROS  = PAD_BITS - CT_BITS;

    // Counters are sized to hold their terminal value, not just the last index.
    localparam int BYTE_CNT_W = $clog2(MSG_BYTES + 1);
    localparam int OUT_CNT_W  = $clog2(OUT_BYTES + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_DRAIN
    } state_e;

endpackage : niederreiter_pkg

// File: rtl/niederreiter_host_sequencer_ct_serializer.sv
// ----------------------------------------------------------------------------
// ct_serializer
//
// Captures the encryptor ciphertext in parallel, left-aligned and zero padded
// to a whole number of bytes, and shifts it out MSB byte first.
//
// Ports
//   clk, rst  : clock, asynchronous active-high reset
//   load_i    : capture ct_i and restart the byte count
//   shift_i   : current byte has been accepted, advance to the next one
//   ct_i      : ciphertext from the encryptor
//   data_o    : byte currently presented (top 8 bits of the shift register)
//   last_o    : the presented byte is the final byte of the frame
// ----------------------------------------------------------------------------
module ct_serializer
    import niederreiter_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               shift_i,
    input  logic [CT_BITS-1:0] ct_i,
    output logic [7:0]         data_o,
    output logic               last_o
);

    localparam logic [OUT_CNT_W-1:0] LAST_IDX = OUT_CNT_W'(OUT_BYTES - 1);

    logic [PAD_BITS-1:0]  shift_q, shift_d;
    logic [OUT_CNT_W-1:0] out_cnt_q, out_cnt_d;

    assign data_o = shift_q[PAD_BITS-1 -: 8];
    assign last_o = (out_cnt_q == LAST_IDX);

    always_comb begin
        shift_d   = shift_q;
        out_cnt_d = out_cnt_q;
        if (load_i) begin
            // Ciphertext MSB lands in bit 7 of the first byte; padding fills
            // the low bits of the final byte.
            shift_d   = {ct_i, {PAD_ZEROS{1'b0}}};
            out_cnt_d = '0;
        end else if (shift_i) begin
            shift_d   = {shift_q[PAD_BITS-9:0], 8'h00};
            out_cnt_d = last_o ? '0 : out_cnt_q + 1'b1;
        end
    end

    // NOTE: this is a plain register, not a RAM, and its contents are visible
    // on out_data, so it takes the reset like every other flop here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q   <= '0;
            out_cnt_q <= '0;
        end else begin
            shift_q   <= shift_d;
            out_cnt_q <= out_cnt_d;
        end
    end

endmodule : ct_serializer

// File: rtl/niederreiter_host_sequencer.sv
// ----------------------------------------------------------------------------
// niederreiter_host_sequencer
//
// Host-side controller for the Niederreiter encryptor. Collects a plaintext
// frame from the host byte stream, writes it into the encryptor, starts it,
// waits for completion under a watchdog, then returns the ciphertext to the
// host as a byte stream.
//
// Parameters
//   TIMEOUT        : watchdog limit in WAIT cycles, 0 disables it
//
// Ports
//   clk, rst       : clock, asynchronous active-high reset
//   in_valid/in_data/in_ready    : plaintext byte stream from the host
//   out_valid/out_data/out_ready : ciphertext byte stream to the host
//   busy           : sequencer is not idle
//   frame_done     : pulse with the final ciphertext byte handshake
//   err            : sticky watchdog timeout, cleared by the next input byte
//   enc_plaintext  : byte written into the encryptor
//   enc_wr_en      : encryptor write strobe, one cycle after each input byte
//   enc_start      : single-cycle encryptor start pulse
//   enc_ciphertext : encryptor result
//   enc_done       : encryptor completion, honoured only while waiting
// ----------------------------------------------------------------------------
module niederreiter_host_sequencer
    import niederreiter_pkg::*;
#(
    parameter int TIMEOUT = 65535
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [7:0]         out_data,
    input  logic               out_ready,
    output logic               busy,
    output logic               frame_done,
    output logic               err,
    output logic [7:0]         enc_plaintext,
    output logic               enc_wr_en,
    output logic               enc_start,
    input  logic [CT_BITS-1:0] enc_ciphertext,
    input  logic               enc_done
);

    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [BYTE_CNT_W-1:0] LAST_IN = BYTE_CNT_W'(MSG_BYTES - 1);
    localparam logic [BYTE_CNT_W-1:0] MSG_LEN = BYTE_CNT_W'(MSG_BYTES);

    state_e                state_q, state_d;
    logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [WD_W-1:0]       wd_cnt_q, wd_cnt_d;
    logic                  err_q, err_d;
    logic [7:0]            enc_pt_q;
    logic                  enc_wr_en_q;
    logic                  enc_start_q;

    logic                  in_hs;
    logic                  out_hs;
    logic                  wd_expire;
    logic                  ser_load;
    logic                  ser_shift;
    logic                  ser_last;
    logic [7:0]            ser_data;

    assign in_hs     = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;
    assign wd_expire = (TIMEOUT != 0) && (wd_cnt_q == WD_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: every clocked assignment is non-blocking so all flops update
    // from the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: each combinational block assigns its outputs a default first,
    // so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_hs) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (in_hs && byte_cnt_q == LAST_IN) state_d = ST_START;
            end
            ST_START: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Completion takes priority over a watchdog expiring in the
                // same cycle.
                if (enc_done)       state_d = ST_DRAIN;
                else if (wd_expire) state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (out_hs && ser_last) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        // in_ready is held low while reset is asserted so the host sees a
        // quiet interface until the sequencer is out of reset.
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        ser_load   = 1'b0;
        ser_shift  = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                in_ready = ~rst;
                busy     = 1'b0;
            end
            ST_LOAD: begin
                in_ready = ~rst && (byte_cnt_q < MSG_LEN);
            end
            ST_START: begin
            end
            ST_WAIT: begin
                ser_load = enc_done;
            end
            ST_DRAIN: begin
                out_valid  = 1'b1;
                ser_shift  = out_hs;
                frame_done = out_hs & ser_last;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign out_data      = out_valid ? ser_data : 8'h00;
    assign err           = err_q;
    assign enc_plaintext = enc_pt_q;
    assign enc_wr_en     = enc_wr_en_q;
    assign enc_start     = enc_start_q;

    // ------------------------------------------------------------------
    // Byte counter, watchdog and error flag
    // ------------------------------------------------------------------
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        wd_cnt_d   = wd_cnt_q;
        err_d      = err_q;

        if (in_hs) begin
            byte_cnt_d = (state_q == ST_IDLE) ? BYTE_CNT_W'(1) : byte_cnt_q + 1'b1;
            err_d      = 1'b0;
        end

        if (state_q == ST_START) begin
            wd_cnt_d = '0;
        end else if (state_q == ST_WAIT && !enc_done) begin
            if (wd_expire) begin
                err_d      = 1'b1;
                byte_cnt_d = '0;
            end else begin
                wd_cnt_d = wd_cnt_q + 1'b1;
            end
        end

        if (state_q == ST_DRAIN && state_d == ST_IDLE) begin
            byte_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_cnt_q  <= '0;
            wd_cnt_q    <= '0;
            err_q       <= 1'b0;
            enc_pt_q    <= 8'h00;
            enc_wr_en_q <= 1'b0;
            enc_start_q <= 1'b0;
        end else begin
            byte_cnt_q  <= byte_cnt_d;
            wd_cnt_q    <= wd_cnt_d;
            err_q       <= err_d;
            // Encryptor strobes are registered: a write follows its
            // handshake by one cycle, and start follows the final write.
            enc_wr_en_q <= in_hs;
            if (in_hs) enc_pt_q <= in_data;
            enc_start_q <= (state_q == ST_START);
        end
    end

    // ------------------------------------------------------------------
    // Ciphertext serializer
    // ------------------------------------------------------------------
    ct_serializer u_ct_serializer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (ser_load),
        .shift_i (ser_shift),
        .ct_i    (enc_ciphertext),
        .data_o  (ser_data),
        .last_o  (ser_last)
    );

endmodule : niederreiter_host_sequencer

// File: doc/niederreiter_host_sequencer.md
# niederreiter_host_sequencer

Host-side controller for the Niederreiter encryptor core. It accepts a plaintext frame as bytes over a valid/ready stream and writes them into the encryptor with `enc_wr_en`, pulses `enc_start`, and waits for `enc_done` under a watchdog. It then captures the 297-bit ciphertext and streams it back to the host as bytes. It sits between the host/bus interface and `encryptor_top`, and is the only block that drives the encryptor's load and start inputs.

## Interface
- `MSG_BYTES`, 40: plaintext bytes per frame.
- `CT_BITS`, 297: ciphertext width from the encryptor.
- `OUT_BYTES`, 38: ceil(CT_BITS/8), the ciphertext bytes returned per frame.
- `TIMEOUT`, 65535: watchdog limit in cycles in WAIT. 0 disables the watchdog.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: host plaintext byte valid.
- `in_data` in 8: plaintext byte, first byte = MSB byte of the message.
- `in_ready` out 1: sequencer accepts a byte.
- `out_valid` out 1: ciphertext byte valid.
- `out_data` out 8: ciphertext byte.
- `out_ready` in 1: host accepts the byte.
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: one-cycle pulse when the last ciphertext byte is accepted.
- `err` out 1: sticky watchdog-timeout flag.
- `enc_plaintext` out 8: byte to the encryptor.
- `enc_wr_en` out 1: write strobe to the encryptor.
- `enc_start` out 1: start pulse to the encryptor.
- `enc_ciphertext` in CT_BITS: encryptor result.
- `enc_done` in 1: encryptor completion.

## Operation
- States: IDLE, LOAD, START, WAIT, DRAIN.
- **IDLE**
  - `in_ready`=1.
  - A handshake (`in_valid & in_ready`) sets `byte_cnt`=1 and moves to LOAD.
- **LOAD**
  - `in_ready`=1 while `byte_cnt` < MSG_BYTES. Each handshake increments `byte_cnt`.
  - When the MSG_BYTES-th byte is accepted, `in_ready` drops in the next cycle and the FSM moves to START.
- **Encryptor write**
  - Every accepted byte produces `enc_wr_en`=1 with `enc_plaintext`=`in_data` in the following cycle (registered).
  - `enc_wr_en` is 0 in all other cycles.
  - Gaps in `in_valid` produce gaps in `enc_wr_en`. Byte order is preserved.
- **START**
  - `enc_start`=1 for exactly one cycle, in the cycle immediately after the last `enc_wr_en`.
  - Then moves to WAIT and clears the watchdog counter.
- **WAIT**
  - `enc_done` sampled high loads `{enc_ciphertext, 7'b0}` into a 304-bit shift register and moves to DRAIN.
  - `enc_done` seen in any other state is ignored.
  - Watchdog (TIMEOUT≠0): the counter increments each WAIT cycle. At TIMEOUT-1 without `enc_done`, set `err`=1, clear `byte_cnt`, and go to IDLE.
- **DRAIN**
  - `out_data` = shift[303:296] and `out_valid`=1.
  - On `out_valid & out_ready`: shift left 8 and increment `out_cnt`.
  - After the OUT_BYTES-th handshake: `frame_done` pulses and the FSM goes to IDLE with `out_valid`=0.
  - The last byte is `{ct[0], 7'b0}`.
- `err` clears on the next accepted input byte and is otherwise sticky.
- `in_ready`=0 in START, WAIT and DRAIN, so the host stalls.

## Timing
- **Reset:** all outputs are 0, including `in_ready`. `in_ready` rises in the first cycle after `rst` deasserts. State = IDLE, all counters = 0, shift register = 0.
- **Reset mid-operation:** the frame is abandoned and nothing is emitted. A partial load is not completed, so the host must resend the whole frame.
- **Input acceptance:** 1 byte/cycle at full rate. With continuous `in_valid`, MSG_BYTES bytes take MSG_BYTES cycles.
- **Load to start:** the last `enc_wr_en` is at cycle N+1 and `enc_start` at N+2, where N is the cycle of the last handshake.
- **Done to output:** first `out_valid` in the cycle after `enc_done` is sampled.
- **Output rate:** full rate, 1 byte/cycle, with `out_ready` held high.
- **Output hold:** `out_data` is stable while `out_valid` is high and `out_ready` is low.
- **Same-cycle `enc_done` and timeout:** `enc_done` wins. No `err`, go to DRAIN.
- **Back-to-back frames:** a new frame can begin in the cycle after `frame_done`.

## Structure
- Package `niederreiter_pkg` holds:
  - MSG_BYTES, CT_BITS, OUT_BYTES and the padded width (OUT_BYTES*8).
  - The state enum.
- Sub-module `ct_serializer`: parallel load of the padded ciphertext, byte shift-out, `out_cnt`, and the last-byte flag.
- The FSM, `byte_cnt`, the watchdog and the encryptor strobes stay in the top.

## Test plan
- **Normal frame:** 40 bytes at full rate, then `enc_done` 100 cycles after `enc_start`.
  - Exactly 40 `enc_wr_en` pulses, bytes in order.
  - `enc_start` one cycle after the last write.
  - 38 output bytes: byte 0 = ct[296:289], byte 37 = `{ct[0], 7'h00}`.
  - `frame_done` on byte 37.
- **Bursty input:** `in_valid` toggling 1/0 across 40 bytes.
  - `enc_wr_en` gaps mirror the input gaps.
  - `enc_start` is still one cycle after write 40.
- **Output backpressure:** `out_ready` low for 5 cycles mid-drain.
  - `out_data` held stable throughout.
  - No byte lost or duplicated; total is still 38.
- **Timeout:** TIMEOUT=16, `enc_done` never asserted.
  - `err`=1 after 16 WAIT cycles, state IDLE, `in_ready`=1.
  - `err` clears on the next accepted byte.
- **Reset mid-load:** `rst` pulsed after byte 20.
  - All outputs are 0 during reset.
  - A following full 40-byte frame completes normally with correct ciphertext.
